// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common host commands
// and the odd-parity helper used when a command byte is latched.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_RELEASE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_LED    = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Parity bit value that makes the 9-bit data+parity word have odd weight.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter (4-sample agreement) with a one-cycle pulse on
// each filtered falling edge. Shared by the host transmitter and the receiver.
module ps2_clk_filter (
  input  logic clk,
  input  logic res,
  input  logic ps2_clk,
  output logic filt,
  output logic fedge
);

  logic [3:0] shreg;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      shreg <= 4'hF;
      filt  <= 1'b1;
      fedge <= 1'b0;
    end else begin
      shreg <= {shreg[2:0], ps2_clk};
      fedge <= filt && (shreg == 4'h0);
      if (shreg == 4'hF)
        filt <= 1'b1;
      else if (shreg == 4'h0)
        filt <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocked
// out by the device, ACK check, with an overall timeout. Open-drain enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       kbd_clk,
  input  logic       kbd_dat,
  output logic       kbd_clk_oe,
  output logic       kbd_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic             filt;
  logic             fedge;
  logic [1:0]       dat_sync;
  logic             dat_s;
  ps2_tx_state_t    state;
  logic [7:0]       sh;
  logic             par;
  logic [3:0]       bitcnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             active;
  logic             timeout;

  ps2_clk_filter u_clk_filter (
    .clk     (clk),
    .res     (res),
    .ps2_clk (kbd_clk),
    .filt    (filt),
    .fedge   (fedge)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res)
      dat_sync <= 2'b11;
    else
      dat_sync <= {dat_sync[0], kbd_dat};
  end

  assign dat_s = dat_sync[1];

  // The timeout window covers everything up to the ACK sample; RELEASE is exempt.
  assign active  = (state == ST_INHIBIT) || (state == ST_REQ) ||
                   (state == ST_SEND)    || (state == ST_ACK);
  assign timeout = active && (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= ST_IDLE;
      sh         <= 8'h00;
      par        <= 1'b0;
      bitcnt     <= 4'd0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      kbd_clk_oe <= 1'b0;
      kbd_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (active && (to_cnt != {TO_W{1'b1}}))
        to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        state      <= ST_IDLE;
        kbd_clk_oe <= 1'b0;
        kbd_dat_oe <= 1'b0;
        tx_busy    <= 1'b0;
        tx_error   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tx_start) begin
              sh         <= tx_data;
              par        <= odd_parity(tx_data);
              bitcnt     <= 4'd0;
              inh_cnt    <= '0;
              to_cnt     <= '0;
              kbd_clk_oe <= 1'b1;
              kbd_dat_oe <= 1'b0;
              tx_busy    <= 1'b1;
              state      <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (inh_cnt >= INH_W'(INHIBIT_CYCLES - 1)) begin
              kbd_dat_oe <= 1'b1;
              state      <= ST_REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          ST_REQ: begin
            kbd_clk_oe <= 1'b0;
            state      <= ST_SEND;
          end
          ST_SEND: begin
            if (fedge) begin
              if (bitcnt <= 4'd7)
                kbd_dat_oe <= ~sh[bitcnt[2:0]];
              else if (bitcnt == 4'd8)
                kbd_dat_oe <= ~par;
              else
                kbd_dat_oe <= 1'b0;
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 4'd9)
                state <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (fedge) begin
              if (dat_s)
                tx_error <= 1'b1;
              else
                tx_done <= 1'b1;
              state <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (filt && dat_s) begin
              tx_busy <= 1'b0;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, a
// cycle-level reference model of the expected pin/flag behaviour, frame checks.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 600;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       kbd_clk_oe, kbd_dat_oe, tx_busy, tx_done, tx_error;
  logic       kbd_clk, kbd_dat;

  assign kbd_clk = ~(kbd_clk_oe | dev_clk_low);
  assign kbd_dat = ~(kbd_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .res        (res),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .kbd_clk    (kbd_clk),
    .kbd_dat    (kbd_dat),
    .kbd_clk_oe (kbd_clk_oe),
    .kbd_dat_oe (kbd_dat_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  int n_done = 0;
  int n_err  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: j counts cycles since the start was accepted, n counts
  // device clock edges seen once the host has released the clock.
  logic [3:0] m_hist = 4'hF;
  logic       m_filt = 1'b1, m_fedge = 1'b0, m_ds1 = 1'b1, m_ds2 = 1'b1;
  logic       m_busy = 1'b0, m_rel = 1'b0;
  logic       m_clk_oe = 1'b0, m_dat_oe = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int         m_k = 0, m_n = 0;
  logic [7:0] m_byte = 8'h00;

  initial begin
    logic p_fe, p_ds, p_fl;
    int   j;
    forever begin
      @(posedge clk or posedge res);
      if (res) begin
        m_hist = 4'hF; m_filt = 1'b1; m_fedge = 1'b0; m_ds1 = 1'b1; m_ds2 = 1'b1;
        m_busy = 1'b0; m_rel = 1'b0; m_clk_oe = 1'b0; m_dat_oe = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_k = 0; m_n = 0;
      end else begin
        p_fe = m_fedge; p_ds = m_ds2; p_fl = m_filt;
        m_fedge = m_filt && (m_hist == 4'h0);
        if (m_hist == 4'hF) m_filt = 1'b1;
        else if (m_hist == 4'h0) m_filt = 1'b0;
        m_hist = {m_hist[2:0], kbd_clk};
        m_ds2 = m_ds1; m_ds1 = kbd_dat;
        m_done = 1'b0; m_err = 1'b0;
        if (!m_busy) begin
          if (tx_start) begin
            m_busy = 1'b1; m_rel = 1'b0; m_k = 0; m_n = 0; m_byte = tx_data;
            m_clk_oe = 1'b1; m_dat_oe = 1'b0;
          end
        end else if (m_rel) begin
          if (p_fl && p_ds) m_busy = 1'b0;
        end else if (m_k + 1 == TMO) begin
          m_err = 1'b1; m_busy = 1'b0; m_clk_oe = 1'b0; m_dat_oe = 1'b0;
        end else begin
          j = m_k + 1;
          m_k++;
          if (j == INH) m_dat_oe = 1'b1;
          if (j == INH + 1) m_clk_oe = 1'b0;
          if (j >= INH + 2 && p_fe) begin
            m_n++;
            if (m_n <= 8) m_dat_oe = ~m_byte[m_n-1];
            else if (m_n == 9) m_dat_oe = ^m_byte;
            else if (m_n == 10) m_dat_oe = 1'b0;
            else begin
              if (p_ds) m_err = 1'b1; else m_done = 1'b1;
              m_rel = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if ({kbd_clk_oe, kbd_dat_oe, tx_busy, tx_done, tx_error} !==
          {m_clk_oe, m_dat_oe, m_busy, m_done, m_err}) begin
        errors++;
        if (nprint < 12)
          $display("FAIL cycle_compare t=%0t got clk_oe,dat_oe,busy,done,err=%b%b%b%b%b expected %b%b%b%b%b",
                   $time, kbd_clk_oe, kbd_dat_oe, tx_busy, tx_done, tx_error,
                   m_clk_oe, m_dat_oe, m_busy, m_done, m_err);
        nprint++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_done) n_done++;
      if (tx_error) n_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Device: waits for request-to-send, clocks n_edges, samples on rising edges.
  task automatic dev_frame(input int n_edges, input bit ack_low, input int poke_edge,
                           output logic [9:0] bits);
    int w = 0;
    bits = '0;
    while (!(kbd_clk === 1'b1 && kbd_dat === 1'b0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL dev_request got none expected request within 200 cycles");
      return;
    end
    repeat (8) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk_low = 1'b1;
      if (e == poke_edge) begin
        @(negedge clk); tx_start = 1'b1; tx_data = 8'($urandom);
        @(negedge clk); tx_start = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (e <= 10) bits[e-1] = kbd_dat;
      dev_clk_low = 1'b0;
      if (e == 11) dev_dat_low = 1'b0;
      if (e == 10) begin
        repeat (3) @(negedge clk);
        dev_dat_low = ack_low;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit ack_low, input int poke,
                      output logic [9:0] bits, output int nd, output int ne);
    int d0 = n_done;
    int e0 = n_err;
    int w  = 0;
    @(negedge clk); tx_data = b; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    dev_frame(11, ack_low, poke, bits);
    while (tx_busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++; errors++;
      $display("FAIL release_wait got busy expected idle within 100 cycles");
    end
    repeat (3) @(negedge clk);
    nd = n_done - d0;
    ne = n_err - e0;
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] b;
    bit         ack;
    int         nd, ne, cnt, e0;

    #1 res = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {kbd_clk_oe, kbd_dat_oe, tx_busy, tx_done, tx_error}, 5'b00000);
    res = 1'b0;
    repeat (4) @(negedge clk);

    send(PS2_CMD_ENABLE, 1'b1, 0, bits, nd, ne);
    check("f4_frame", bits, 10'b1_0_11110100);
    check("f4_done", nd, 1);
    check("f4_err", ne, 0);
    check("f4_busy_after", tx_busy, 0);

    send(PS2_CMD_LED, 1'b1, 0, bits, nd, ne);
    check("ed_frame", bits, 10'b1_1_11101101);
    check("ed_done", nd, 1);

    send(8'h00, 1'b1, 0, bits, nd, ne);
    check("00_frame", bits, 10'b1_1_00000000);

    send(8'h01, 1'b1, 0, bits, nd, ne);
    check("01_frame", bits, 10'b1_0_00000001);

    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      send(b, ack, 0, bits, nd, ne);
      check("rand_frame", bits, {1'b1, ~^b, b});
      check("rand_done", nd, ack ? 1 : 0);
      check("rand_err", ne, ack ? 0 : 1);
    end

    send(PS2_CMD_ENABLE, 1'b0, 0, bits, nd, ne);
    check("noack_done", nd, 0);
    check("noack_err", ne, 1);

    send(8'hA5, 1'b1, 5, bits, nd, ne);
    check("poke_frame", bits, 10'b1_1_10100101);
    check("poke_done", nd, 1);
    check("poke_err", ne, 0);

    e0 = n_err;
    @(negedge clk); tx_data = 8'h3C; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    cnt = 0;
    while (tx_busy && cnt < TMO + 50) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_busy_cycles", cnt, TMO);
    check("timeout_err_pulse", tx_error, 1);
    check("timeout_done", tx_done, 0);
    check("timeout_enables", {kbd_clk_oe, kbd_dat_oe}, 2'b00);
    repeat (3) @(negedge clk);
    check("timeout_err_count", n_err - e0, 1);

    @(negedge clk); tx_data = 8'h00; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    dev_frame(5, 1'b1, 0, bits);
    check("rst_pre_dat_oe", kbd_dat_oe, 1);
    #1 res = 1'b1;
    #1 check("rst_mid_outputs", {kbd_clk_oe, kbd_dat_oe, tx_busy}, 3'b000);
    @(negedge clk); res = 1'b0;
    repeat (5) @(negedge clk);
    send(PS2_CMD_RESET, 1'b1, 0, bits, nd, ne);
    check("ff_frame", bits, 10'b1_1_11111111);
    check("ff_done", nd, 1);
    check("ff_err", ne, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
